imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which is the immediate output width; the only legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 32, which is the width of the sideband tag (PC or ROB id) passed through unchanged.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, which marks the upstream instruction as valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, which indicates the block can accept an instruction this cycle.
REQ-007 The block SHALL have port in_instr, input, 32 bits, the raw RV32 instruction word; the opcode SHALL be taken from in_instr[6:0] and SHALL have no separate port.
REQ-008 The block SHALL have port in_tag, input, TAG_W bits, the sideband tag.
REQ-009 The block SHALL have port out_valid, output, 1 bit, which marks the result as valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, which indicates the downstream stage accepts the result.
REQ-011 The block SHALL have port out_imm, output, XLEN bits, the sign-extended immediate.
REQ-012 The block SHALL have port out_fmt, output, of type imm_fmt_e, the decoded immediate format.
REQ-013 The block SHALL have port out_illegal, output, 1 bit, set when the opcode is unsupported.
REQ-014 The block SHALL have port out_tag, output, TAG_W bits, the tag carried with the result.

Function
REQ-015 The block SHALL decode the I format for opcodes 0000011, 0010011, 1100111 and 1110011; imm = sext(instr[31:20]).
REQ-016 The block SHALL decode the S format for opcode 0100011; imm = sext({instr[31:25], instr[11:7]}).
REQ-017 The block SHALL decode the B format for opcode 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-018 The block SHALL decode the U format for opcodes 0110111 and 0010111; imm = sext({instr[31:12], 12'b0}).
REQ-019 The block SHALL decode the J format for opcode 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-020 For the R format (opcode 0110011), imm SHALL be 0 and illegal SHALL be 0.
REQ-021 For any other opcode, fmt SHALL be FMT_NONE, imm SHALL be 0 and illegal SHALL be 1.
REQ-022 All sign extension SHALL replicate instr[31] up to XLEN bits.
REQ-023 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-024 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output is empty; sustained throughput SHALL be 1 per cycle when out_ready=1.
REQ-025 Buffering SHALL be 2 entries: an output register plus a skid register; in_ready SHALL be driven from a register (!skid_valid), with no combinational path from out_ready.
REQ-026 When the output is stalled and an input transfer occurs, the result SHALL go to the skid register and in_ready SHALL drop the next cycle.
REQ-027 When the output transfers while the skid register is full, the skid register SHALL move to the output register and in_ready SHALL rise the next cycle.
REQ-028 Results SHALL leave in input order, with none dropped or duplicated.
REQ-029 While out_valid=1 && out_ready=0, out_imm, out_fmt, out_illegal and out_tag SHALL hold stable.

Reset
REQ-030 When reset=1 at a clock edge, out_valid=0, the skid register SHALL be empty and in_ready=1 on the next cycle.
REQ-031 On reset, out_imm=0, out_fmt=FMT_NONE, out_illegal=0 and out_tag=0.
REQ-032 A reset asserted mid-stall SHALL discard both buffered entries, and the block SHALL NOT output them after reset.
REQ-033 An input presented during the reset cycle SHALL NOT be accepted.

Configuration
REQ-034 When IMM_GEN_ZICSR_EN is defined, opcode 1110011 with funct3[2]=1 SHALL decode as FMT_Z with imm = zero-extended instr[19:15].
REQ-035 When IMM_GEN_ZICSR_EN is undefined, all 1110011 opcodes SHALL decode as I format, and FMT_Z SHALL never be produced.

Structure
REQ-036 Package imm_gen_pkg SHALL contain enum imm_fmt_e {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z} and the opcode localparams.
REQ-037 The handshake buffering SHALL live in sub-module imm_skid_buf, parametrised by payload width; the decode logic SHALL be combinational in imm_gen_pipe.

Verification
REQ-038 Load decode: 0xFFC12083 (lw x1,-4(x2)) -> 1 cycle later out_imm=0xFFFFFFFC, fmt=FMT_I, illegal=0; with XLEN=64, out_imm=0xFFFFFFFFFFFFFFFC.
REQ-039 Store/branch decode: 0xFE112E23 -> imm 0xFFFFFFFC, FMT_S; 0xFE000CE3 -> imm 0xFFFFFFF8, FMT_B.
REQ-040 Upper-immediate and illegal decode: 0x123450B7 -> imm 0x12345000, FMT_U; 0x0000007F -> illegal=1, imm=0, FMT_NONE.
REQ-041 Backpressure: stream 4 tagged instructions with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, no loss, tags emitted in order 0,1,2,3.
REQ-042 Reset mid-stall: with both entries full, assert reset for 1 cycle -> out_valid=0, in_ready=1, and neither old entry ever appears.
REQ-043 Configuration: 0x3002D073 -> with IMM_GEN_ZICSR_EN imm=5, FMT_Z; without it imm=0x300, FMT_I.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate-generator pipeline stage.
//
// Contents:
//   imm_fmt_e  - decoded immediate format carried alongside each result
//   OPC_*      - RV32 major opcodes (instr[6:0]) that select an immediate format
//   FMT_W      - bit width of imm_fmt_e, used when packing the format into a payload
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_Z
  } imm_fmt_e;

  localparam int unsigned FMT_W = $bits(imm_fmt_e);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus a skid register.
//
// in_ready_o is a pure register output (!skid_valid_q), so there is no combinational path
// from out_ready_i to in_ready_o. Data leaves in arrival order; the output register holds
// steady while stalled.
//
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - synchronous active-high reset; empties both entries, zeroes the data
//   in_valid_i   - upstream data valid
//   in_ready_o   - buffer can accept this cycle
//   in_data_i    - upstream payload (Width bits)
//   out_valid_o  - output register holds valid data
//   out_ready_i  - downstream accepts
//   out_data_o   - output payload (Width bits)
module imm_skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;

  logic in_xfer;
  logic out_free;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  assign in_xfer  = in_valid_i & ~skid_valid_q;
  // Output slot is free this cycle if empty or being drained.
  assign out_free = ~out_valid_q | out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; in_xfer is necessarily low here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator pipeline stage: decodes the RV32 immediate of an incoming instruction
// and presents it, sign-extended to XLEN, one cycle later behind a two-entry skid buffer.
//
// Optional feature: define IMM_GEN_ZICSR_EN to decode SYSTEM opcodes with funct3[2]=1 as
// FMT_Z (zero-extended 5-bit uimm from instr[19:15]); otherwise all SYSTEM opcodes are I.
//
// Parameters:
//   XLEN   - immediate output width, 32 or 64
//   TAG_W  - sideband tag width (PC or ROB id), passed through unchanged
// Ports:
//   clk, reset               - clock and synchronous active-high reset
//   in_valid/in_ready        - upstream handshake; in_ready is registered
//   in_instr, in_tag         - raw instruction word and sideband tag
//   out_valid/out_ready      - downstream handshake
//   out_imm, out_fmt         - sign-extended immediate and decoded format
//   out_illegal, out_tag     - unsupported-opcode flag and carried tag
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam int unsigned PayloadW = XLEN + FMT_W + 1 + TAG_W;

  logic [6:0]          opcode;
  logic [31:0]         imm32;
  logic [XLEN-1:0]     dec_imm;
  imm_fmt_e            dec_fmt;
  logic                dec_illegal;
  logic [PayloadW-1:0] in_payload;
  logic [PayloadW-1:0] out_payload;
  logic [FMT_W-1:0]    out_fmt_bits;

  assign opcode = in_instr[6:0];

  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (in_instr[14]) begin
          dec_fmt = FMT_Z;
          imm32   = {27'b0, in_instr[19:15]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
`else
        dec_fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      OPC_OP: begin
        dec_fmt = FMT_R;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Every 32-bit immediate above is already sign-correct (FMT_Z has bit 31 clear), so a signed
  // widen to XLEN replicates instr[31] where required.
  assign dec_imm = XLEN'($signed(imm32));

  assign in_payload = {dec_imm, dec_fmt, dec_illegal, in_tag};

  imm_skid_buf #(
    .Width(PayloadW)
  ) u_skid_buf (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_payload),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_payload)
  );

  assign {out_imm, out_fmt_bits, out_illegal, out_tag} = out_payload;
  assign out_fmt = imm_fmt_e'(out_fmt_bits);

endmodule
